// File: rtl/keyline_pkg.sv
// keyline_pkg: shared types and constants for the keyline_buf key-entry buffer.
//   rpt_state_t   : auto-repeat FSM states (IDLE, HOLD, REPEAT)
//   KL_NDIGITS    : default number of digit slots
//   KL_DW         : default bits per digit
//   cw_of()       : width of a counter that must hold 0..n inclusive
package keyline_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int KL_NDIGITS = 8;
  localparam int KL_DW      = 4;

  function automatic int cw_of(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/keyline_repeat.sv
// keyline_repeat: key press qualification and optional auto-repeat.
// Turns the level key_in_i into a one-cycle event strobe. With the macro
// KEYLINE_REPEAT_EN defined, a hold timer and a latched digit generate extra
// events while the key stays held.
// Ports:
//   clock_i     : clock, rising edge
//   reset_i     : asynchronous active-high reset
//   key_in_i    : level, high while a key is held
//   key_val_i   : digit of the held key
//   clear_i     : buffer clear; also returns the repeat FSM to IDLE
//   taken_i     : the top level accepted this cycle's event into the buffer
//   evt_o       : key event strobe (fresh press or repeat)
//   evt_val_o   : digit to shift in with evt_o
module keyline_repeat
  import keyline_pkg::*;
#(
  parameter int DW            = KL_DW,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          key_in_i,
  input  logic [DW-1:0] key_val_i,
  input  logic          clear_i,
  input  logic          taken_i,
  output logic          evt_o,
  output logic [DW-1:0] evt_val_o
);

  logic key_q;
  logic edge_evt;

  // A key already held when reset is released must not count as a press:
  // key_q comes out of reset as "held", so only a release followed by a new
  // rising edge produces an event.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the values from before the edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) key_q <= 1'b1;
    else         key_q <= key_in_i;
  end

  assign edge_evt = key_in_i & ~key_q;

`ifdef KEYLINE_REPEAT_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  rpt_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DW-1:0] latch_q, latch_d;
  logic          rpt_evt;

  // Kept apart from the next-state logic: taken_i depends on evt_o, so the
  // strobe must not be computed in the same block that consumes taken_i.
  assign rpt_evt = (state_q != IDLE) && (timer_q == '0) && key_in_i && !clear_i;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      timer_q <= '0;
      latch_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      latch_q <= latch_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    latch_d = latch_q;
    unique case (state_q)
      IDLE: begin
        // Only a press that actually entered the buffer arms the repeat.
        if (edge_evt && taken_i) begin
          state_d = HOLD;
          timer_d = TW'(REPEAT_DELAY - 1);
          latch_d = key_val_i;
        end
      end
      HOLD, REPEAT: begin
        // A rejected repeat still advances to/stays in REPEAT.
        if (timer_q == '0) begin
          state_d = REPEAT;
          timer_d = TW'(REPEAT_PERIOD - 1);
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && (!key_in_i || clear_i)) state_d = IDLE;
  end

  assign evt_o     = edge_evt | rpt_evt;
  assign evt_val_o = rpt_evt ? latch_q : key_val_i;
`else
  logic unused_inputs;
  assign unused_inputs = clear_i ^ taken_i;

  assign evt_o     = edge_evt;
  assign evt_val_o = key_val_i;
`endif

endmodule

// File: rtl/keyline_buf.sv
// keyline_buf: parametrised key-entry line buffer.
// Shifts edge-qualified key digits into an NDIGITS x DW register (newest digit
// in the low bits), tracks the digit count, and supports backspace, clear and
// a selectable full-buffer policy. Optional auto-repeat is built when the
// macro KEYLINE_REPEAT_EN is defined.
// Ports:
//   clock     : clock, rising edge
//   reset     : asynchronous active-high reset
//   key_in    : level, high while a key is held
//   key_val   : digit of the held key
//   backspace : level; rising edge removes the newest digit
//   clear     : level; while high, empties the buffer and clears overflow
//   overwrite : full policy, 1 = drop oldest digit, 0 = reject new digit
//   out       : buffer contents
//   count     : number of valid digits, 0..NDIGITS
//   full      : count == NDIGITS
//   empty     : count == 0
//   overflow  : sticky, set when a digit is dropped or rejected
//   accept    : one-cycle pulse when a digit enters the buffer
module keyline_buf
  import keyline_pkg::*;
#(
  parameter  int NDIGITS       = KL_NDIGITS,
  parameter  int DW            = KL_DW,
  parameter  int REPEAT_DELAY  = 500000,
  parameter  int REPEAT_PERIOD = 100000,
  localparam int CW            = cw_of(NDIGITS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 key_in,
  input  logic [DW-1:0]        key_val,
  input  logic                 backspace,
  input  logic                 clear,
  input  logic                 overwrite,
  output logic [NDIGITS*DW-1:0] out,
  output logic [CW-1:0]        count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic                 accept
);

  localparam int BW = NDIGITS * DW;

  logic [BW-1:0] out_q, out_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          acc_q, acc_d;
  logic          bs_q;
  logic          bs_evt;
  logic          key_evt;
  logic [DW-1:0] evt_val;
  logic          is_full;

  keyline_repeat #(
    .DW            (DW),
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_repeat (
    .clock_i   (clock),
    .reset_i   (reset),
    .key_in_i  (key_in),
    .key_val_i (key_val),
    .clear_i   (clear),
    .taken_i   (acc_d),
    .evt_o     (key_evt),
    .evt_val_o (evt_val)
  );

  assign bs_evt  = backspace & ~bs_q;
  assign is_full = (count_q == CW'(NDIGITS));

  // Priority: clear, then backspace, then key; losers are dropped, not queued.
  always_comb begin
    out_d   = out_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    acc_d   = 1'b0;
    if (clear) begin
      out_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (bs_evt) begin
      if (count_q != '0) begin
        out_d   = out_q >> DW;
        count_d = count_q - CW'(1);
      end
    end else if (key_evt) begin
      if (!is_full) begin
        out_d   = {out_q[BW-DW-1:0], evt_val};
        count_d = count_q + CW'(1);
        acc_d   = 1'b1;
      end else begin
        ovf_d = 1'b1;
        if (overwrite) begin
          out_d = {out_q[BW-DW-1:0], evt_val};
          acc_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      acc_q   <= 1'b0;
      bs_q    <= 1'b0;
    end else begin
      out_q   <= out_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      acc_q   <= acc_d;
      bs_q    <= backspace;
    end
  end

  assign out      = out_q;
  assign count    = count_q;
  assign overflow = ovf_q;
  assign accept   = acc_q;
  assign full     = is_full;
  assign empty    = (count_q == '0);

endmodule

// File: tb/tb_keyline_buf.sv
module tb_keyline_buf;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int CW = $clog2(ND + 1);

  logic              clock;
  logic              reset;
  logic              key_in;
  logic [DW-1:0]     key_val;
  logic              backspace;
  logic              clear;
  logic              overwrite;
  logic [ND*DW-1:0]  out;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              accept;

  int n_cmp = 0;
  int n_bad = 0;

  keyline_buf #(
    .NDIGITS       (ND),
    .DW            (DW),
    .REPEAT_DELAY  (5),
    .REPEAT_PERIOD (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .key_in    (key_in),
    .key_val   (key_val),
    .backspace (backspace),
    .clear     (clear),
    .overwrite (overwrite),
    .out       (out),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .accept    (accept)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Hold a key for 'hold' cycles, release for one, report accepts seen.
  task automatic press(input logic [DW-1:0] v, input int hold,
                       output int n_acc, output logic first_acc);
    key_val = v;
    key_in  = 1'b1;
    n_acc   = 0;
    first_acc = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (i == 0) first_acc = accept;
      if (accept) n_acc++;
    end
    key_in = 1'b0;
    step();
    if (accept) n_acc++;
  endtask

  task automatic bs_press();
    backspace = 1'b1;
    step();
    backspace = 1'b0;
    step();
  endtask

  int          n_acc;
  logic        first_acc;
  logic [15:0] bs_exp [4];
  logic [15:0] acc_mask;
  logic [15:0] acc_exp;

  initial begin
    bs_exp = '{16'h0234, 16'h0023, 16'h0002, 16'h0000};
    reset = 1'b1; key_in = 1'b0; key_val = '0; backspace = 1'b0;
    clear = 1'b0; overwrite = 1'b0;
    #12;
    check("rst_out", 32'(out), 32'h0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_accept", 32'(accept), 32'd0);
    reset = 1'b0;
    step(); step();

    // Keys 1,2,3 each held 4 cycles.
    for (int k = 1; k <= 3; k++) begin
      press(DW'(k), 4, n_acc, first_acc);
      check($sformatf("key%0d_acc_latency", k), 32'(first_acc), 32'd1);
      check($sformatf("key%0d_acc_count", k), 32'(n_acc), 32'd1);
    end
    check("k123_out", 32'(out), 32'h0123);
    check("k123_count", 32'(count), 32'd3);

    press(4'h4, 2, n_acc, first_acc);
    check("k4_out", 32'(out), 32'h1234);
    check("k4_full", 32'(full), 32'd1);
    check("k4_ovf", 32'(overflow), 32'd0);

    // Full, overwrite=0: rejected.
    overwrite = 1'b0;
    press(4'h5, 3, n_acc, first_acc);
    check("rej_out", 32'(out), 32'h1234);
    check("rej_ovf", 32'(overflow), 32'd1);
    check("rej_acc", 32'(n_acc), 32'd0);

    // Full, overwrite=1: oldest digit dropped.
    overwrite = 1'b1;
    press(4'h6, 3, n_acc, first_acc);
    check("ovw_out", 32'(out), 32'h2346);
    check("ovw_count", 32'(count), 32'd4);
    check("ovw_acc", 32'(n_acc), 32'd1);

    // Backspace down to empty, overflow stays sticky.
    for (int i = 0; i < 4; i++) begin
      bs_press();
      check($sformatf("bs%0d_out", i), 32'(out), 32'(bs_exp[i]));
    end
    bs_press();
    check("bs_empty_out", 32'(out), 32'h0);
    check("bs_empty_count", 32'(count), 32'd0);
    check("bs_empty_ovf", 32'(overflow), 32'd1);
    check("bs_empty_flag", 32'(empty), 32'd1);

    clear = 1'b1; step(); clear = 1'b0; step();
    check("clr_ovf", 32'(overflow), 32'd0);

    for (int k = 1; k <= 3; k++) press(DW'(k), 2, n_acc, first_acc);
    check("k123b_out", 32'(out), 32'h0123);
    backspace = 1'b1;
    step();
    check("bs_out", 32'(out), 32'h0012);
    check("bs_count", 32'(count), 32'd2);
    step();
    check("bs_held_out", 32'(out), 32'h0012);
    backspace = 1'b0;
    step();

    // Key, backspace and clear in one cycle: clear wins, key is discarded.
    key_val = 4'h9; key_in = 1'b1; backspace = 1'b1; clear = 1'b1;
    step();
    check("all3_out", 32'(out), 32'h0);
    check("all3_count", 32'(count), 32'd0);
    check("all3_ovf", 32'(overflow), 32'd0);
    check("all3_acc", 32'(accept), 32'd0);
    clear = 1'b0; backspace = 1'b0;
    step();
    check("all3_nodefer_acc", 32'(accept), 32'd0);
    check("all3_nodefer_count", 32'(count), 32'd0);
    key_in = 1'b0;
    step();

`ifdef KEYLINE_REPEAT_EN
    // Key 7 held 15 cycles: accepts after edges 1,6,9,12,15.
    overwrite = 1'b1;
    key_val = 4'h7; key_in = 1'b1;
    acc_mask = '0;
    for (int i = 1; i <= 15; i++) begin
      step();
      acc_mask[i] = accept;
      if (i == 12) begin
        check("rpt12_out", 32'(out), 32'h7777);
        check("rpt12_ovf", 32'(overflow), 32'd0);
      end
    end
    acc_exp = 16'b1001_0010_0100_0010;
    check("rpt_acc_mask", 32'(acc_mask), 32'(acc_exp));
    check("rpt15_ovf", 32'(overflow), 32'd1);
    check("rpt15_count", 32'(count), 32'd4);
    key_in = 1'b0;
    step();
    clear = 1'b1; step(); clear = 1'b0; step();
`endif

    // Reset mid-hold (mid-repeat in the repeat build).
    key_val = 4'h7; key_in = 1'b1;
    for (int i = 0; i < 8; i++) step();
`ifdef KEYLINE_REPEAT_EN
    check("prerst_out", 32'(out), 32'h0077);
`else
    check("prerst_out", 32'(out), 32'h0007);
`endif
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(out), 32'h0);
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    step();
    reset = 1'b0;
    // Key still held after reset: no event until released and re-pressed.
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (accept) n_acc++;
    end
    check("post_rst_held_acc", 32'(n_acc), 32'd0);
    check("post_rst_held_count", 32'(count), 32'd0);
    key_in = 1'b0;
    step();
    key_in = 1'b1;
    step();
    check("repress_acc", 32'(accept), 32'd1);
    check("repress_out", 32'(out), 32'h0007);
    key_in = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
